// File: rtl/fpm_pkg.sv
// Shared constants and beat types for the binary32 multiplier normalize stage.
package fpm_pkg;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;
   localparam int MW      = 48;
   localparam int ZW      = 27;

   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100
   } rmode_e;

   typedef struct packed {
      logic          sign;
      logic [7:0]    exp;
      logic [ZW-1:0] z;
      rmode_e        rmode;
      logic          zero;
      logic          ovf;
      logic          tiny;
   } norm_beat_t;
endpackage

// File: rtl/fpm_lzc48.sv
// 48-bit leading-zero counter: nibble encoders, then 16-bit groups, then top pick.
module fpm_lzc48 (
   input  logic [47:0] x,
   output logic [5:0]  lz
);
   logic [11:0]      nib_v;
   logic [11:0][1:0] nib_c;
   logic [2:0]       grp_v;
   logic [3:0][3:0]  grp_c;
   logic [1:0]       top_sel;

   function automatic logic [1:0] enc4(input logic [3:0] v);
      casez (v)
         4'b1???: return 2'd0;
         4'b01??: return 2'd1;
         4'b001?: return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   for (genvar n = 0; n < 12; n++) begin : g_nib
      assign nib_v[n] = |x[4*n +: 4];
      assign nib_c[n] = enc4(x[4*n +: 4]);
   end

   for (genvar g = 0; g < 3; g++) begin : g_grp
      logic [1:0]      sel;
      logic [3:0][1:0] cs;
      assign cs       = nib_c[4*g +: 4];
      assign grp_v[g] = |nib_v[4*g +: 4];
      assign sel      = enc4(nib_v[4*g +: 4]);
      assign grp_c[g] = {sel, cs[2'd3 - sel]};
   end

   // Slot 3 is the all-zero case: top_sel=3 with a zero group count yields 48.
   assign grp_c[3] = '0;
   assign top_sel  = enc4({grp_v, 1'b1});
   assign lz       = {top_sel, grp_c[2'd2 - top_sel]};
endmodule

// File: rtl/fpm_normalize.sv
// Two-stage elastic normalizer: stage 1 counts leading zeros and adjusts the
// exponent, stage 2 shifts into the {mant24, G, R, S} word for the rounder.
module fpm_normalize #(
   parameter int MW = 48,
   parameter int EW = 10,
   parameter int ZW = 27
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_sign,
   input  logic [EW-1:0] in_exp,
   input  logic [MW-1:0] in_mant,
   input  logic [2:0]    in_rmode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_sign,
   output logic [7:0]    out_exp,
   output logic [ZW-1:0] out_z,
   output logic [2:0]    out_rmode,
   output logic          out_zero,
   output logic          out_ovf,
   output logic          out_tiny
);
   import fpm_pkg::*;

   logic                 s1_valid, s2_valid, s1_advance;
   logic [5:0]           lz_d, s1_lz;
   logic signed [EW:0]   exp_adj_d, s1_exp;
   logic                 s1_zero, s1_sign;
   logic [MW-1:0]        s1_mant;
   rmode_e               s1_rmode;
   norm_beat_t           s2, nb;
   logic signed [EW+1:0] shamt, rsh_n;
   logic [MW-1:0]        p;
   logic [MW+49:0]       ext;
   logic                 lo;

   assign s1_advance = !s2_valid || out_ready;
   assign in_ready   = !s1_valid || s1_advance;

   fpm_lzc48 u_lzc (.x(in_mant), .lz(lz_d));

   assign exp_adj_d = {in_exp[EW-1], in_exp} + (EW+1)'(1) - (EW+1)'(lz_d);

   // Subnormal alignment: S = lz + exp_adj - 1 places the value at exponent 1.
   assign shamt = (EW+2)'(s1_exp) + (EW+2)'(s1_lz) - (EW+2)'(1);
   assign rsh_n = -shamt;

   always_comb begin
      nb       = '0;
      p        = '0;
      ext      = '0;
      lo       = 1'b0;
      nb.sign  = s1_sign;
      nb.rmode = s1_rmode;
      if (s1_zero) begin
         nb.zero = 1'b1;
      end else if (s1_exp >= (EW+1)'(1)) begin
         p      = s1_mant << s1_lz;
         nb.ovf = s1_exp >= (EW+1)'(EXP_MAX);
         nb.exp = nb.ovf ? 8'hFF : s1_exp[7:0];
      end else begin
         nb.tiny = 1'b1;
         if (!shamt[EW+1]) begin
            p = s1_mant << shamt[5:0];
         end else if (rsh_n >= (EW+2)'(50)) begin
            lo = |s1_mant;
         end else begin
            // 50 guard zeros below the mantissa keep every shifted-out bit for sticky.
            ext = {s1_mant, 50'b0} >> rsh_n[5:0];
            p   = ext[MW+49:50];
            lo  = |ext[49:0];
         end
      end
      nb.z = {p[MW-1:MW-24], p[MW-25], p[MW-26], (|p[MW-27:0]) | lo};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s1_lz    <= '0;
         s1_exp   <= '0;
         s1_zero  <= 1'b0;
         s1_sign  <= 1'b0;
         s1_mant  <= '0;
         s1_rmode <= RNE;
         s2       <= '0;
      end else begin
         if (in_ready)   s1_valid <= in_valid;
         if (s1_advance) s2_valid <= s1_valid;
         if (in_valid && in_ready) begin
            s1_lz    <= lz_d;
            s1_exp   <= exp_adj_d;
            s1_zero  <= (in_mant == '0);
            s1_sign  <= in_sign;
            s1_mant  <= in_mant;
            s1_rmode <= rmode_e'(in_rmode);
         end
         if (s1_valid && s1_advance) s2 <= nb;
      end
   end

   assign out_valid = s2_valid;
   assign out_sign  = s2.sign;
   assign out_exp   = s2.exp;
   assign out_z     = s2.z;
   assign out_rmode = s2.rmode;
   assign out_zero  = s2.zero;
   assign out_ovf   = s2.ovf;
   assign out_tiny  = s2.tiny;
endmodule

// File: doc/fpm_normalize.md
Name: fpm_normalize

Overview:
- Normalizes the raw 48-bit mantissa product and pre-biased exponent from the multiplier array into the 27-bit {mant24, guard, round, sticky} word the rounding stage consumes.
- Handles the 1-bit product overflow, subnormal operands through a leading-zero count, and gradual underflow through a right shift with sticky collection.
- Two-stage elastic pipeline with valid/ready on both sides, between the mantissa multiplier and the rounder.

Parameters:
- MW, 48, product mantissa width (fixed 2×24 for binary32)
- EW, 10, signed exponent input width
- ZW, 27, output significand width (24 + G + R + S)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept input
- in_sign  in  1  product sign
- in_exp  in  EW  signed biased exponent (eA+eB−127), hidden bit assumed at product bit 46
- in_mant  in  MW  unsigned raw product
- in_rmode  in  3  rounding mode, passed through unchanged
- out_valid  out  1  output beat valid
- out_ready  in  1  rounder accepts
- out_sign  out  1  sign
- out_exp  out  8  biased result exponent
- out_z  out  ZW  significand to rounder: [26:3] mant, [2] guard, [1] round, [0] sticky
- out_rmode  out  3  rounding mode
- out_zero  out  1  product mantissa was zero
- out_ovf  out  1  exp_adj ≥ 255
- out_tiny  out  1  exp_adj < 1 (subnormal/underflow path)

Behaviour:
- Reset: s1_valid=0, s2_valid=0. All outputs are 0, in_ready=1.
- Handshake: a beat transfers when valid & ready. in_ready = !s1_valid | s1_advance. s1_advance = !s2_valid | out_ready. Payload registers load only on transfer. Order is preserved. There are no bubbles under continuous flow: 1 beat per cycle.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready=1.
- Stage 1 registers the following:
  - lz = leading zeros of in_mant (0..48).
  - exp_adj = in_exp + 1 − lz, signed, EW+1 bits.
  - zero = (in_mant==0).
  - Also registers the raw mant, sign and rmode.
- Stage 2 performs the shift:
  - zero: out_z=0, out_exp=0, out_zero=1, ovf=0, tiny=0.
  - exp_adj ≥ 1: left shift mant by lz. out_z = {p[47:24], p[23], p[22], |p[21:0]}. out_exp = exp_adj[7:0] saturated to 255.
  - exp_adj < 1: compute S = lz + exp_adj − 1.
    - If S ≥ 0, left shift by S.
    - Else logical right shift by −S, with every bit shifted out ORed into sticky. A shift of ≥ 50 saturates to all-sticky: out_z = {26'b0, |mant}.
    - out_exp = 0, tiny = 1.
  - exp_adj ≥ 255: ovf=1, out_exp=8'hFF, out_z is the normalized value. Inf selection is done downstream.
- Sticky is the OR of all discarded bits below round. It is never lost through the right shift.
- Rounding carry (mant all-ones +1) is not handled here. The rounder's renormalize output and the exponent increment belong to the packing stage.
- Stall: with out_ready=0, s2 holds its value and s1 fills, then in_ready drops. When out_ready=1 and in_valid=1 occur in the same cycle, both stages advance together.
- Reset mid-operation discards all in-flight beats. out_valid drops asynchronously.

Decomposition:
- fpm_pkg holds the following:
  - localparams BIAS=127, EXP_MAX=255, MW, ZW.
  - typedef rmode_e matching the rounder encodings RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100.
  - Packed struct norm_beat_t {sign, exp, z, rmode, zero, ovf, tiny}.
- Sub-module fpm_lzc48: combinational 48-bit leading-zero counter, tree of 4-bit encoders, 6-bit output, output 48 for zero input.

Test Plan:
- Normal, no carry: in_mant=48'h4000_0000_0000, in_exp=127 → out_z=27'h400_0000, out_exp=127, flags 0, 2 cycles later.
- Product carry: in_mant=48'h9000_0000_0000, in_exp=127 → out_exp=128, out_z=27'h480_0000. Sticky case: in_mant=48'h8000_0000_0001, in_exp=127 → out_z=27'h400_0001.
- Subnormal output: in_mant=48'h4000_0000_0000, in_exp=−2 → out_exp=0, out_z=27'h080_0000, tiny=1. With in_exp=−200 → out_z=27'h000_0001.
- Zero/overflow: in_mant=0 → out_zero=1, out_z=0. in_mant=48'h4000_0000_0000, in_exp=300 → ovf=1, out_exp=8'hFF.
- Backpressure: 4 back-to-back beats with out_ready=0 for 3 cycles → in_ready low after 2 accepted. All 4 beats emerge in order, none duplicated.
- Async reset asserted with both stages full → out_valid=0 immediately, in_ready=1 after release. The next beat is output with 2-cycle latency.
